signed_alu_pipe: RTL
====================

// Module: signed_alu_pipe
// PURPOSE
//   Parametrised, pipelined signed arithmetic unit. Performs add, sub, mul, neg, abs and compare
//   on WIDTH-bit two's-complement operands, with per-transaction wrap or saturate mode,
//   overflow flagging and a sticky overflow event counter. Sits between operand producers
//   and result consumers on valid/ready streams; a generalised, clocked successor of the
//   fixed 8-bit signed edge-case arithmetic checks.
// PARAMETERS
//   WIDTH   8   operand width (bits), >= 2; result is 2*WIDTH bits signed
//   CNT_W   8   width of the overflow event counter
// PORTS
//   clk         in   1        clock, all state on rising edge
//   rst_n       in   1        asynchronous active-low reset
//   in_valid    in   1        operand beat valid
//   in_ready    out  1        unit can accept an operand beat
//   op          in   3        0 ADD, 1 SUB, 2 MUL, 3 NEG(a), 4 ABS(a), 5 CMP, 6-7 reserved
//   sat_en      in   1        1 = saturate on overflow, 0 = wrap
//   a           in   WIDTH    signed operand A
//   b           in   WIDTH    signed operand B (ignored by NEG/ABS)
//   out_valid   out  1        result beat valid
//   out_ready   in   1        consumer accepts result beat
//   result      out  2*WIDTH  signed result
//   ovf         out  1        this result overflowed WIDTH bits
//   cmp_gt      out  1        signed a > b (CMP only, else 0)
//   cmp_eq      out  1        a == b (CMP only, else 0)
//   clr_count   in   1        synchronous clear of ovf_count
//   ovf_count   out  CNT_W    overflow events since reset or clear; saturates at all-ones
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): both stage valids 0, out_valid 0, result 0, ovf 0, cmp_gt 0,
//     cmp_eq 0, ovf_count 0. in_ready is 1 once rst_n is high (combinational).
//   Pipeline: two register stages, S1 and S2. Latency is 2 cycles from the input handshake to
//     out_valid with no backpressure. Full throughput is 1 beat/cycle.
//   Handshake: a beat transfers when valid & ready are both 1 on a rising edge.
//     s2_adv = ~s2_valid | out_ready. s1_adv = ~s1_valid | s2_adv. in_ready = s1_adv.
//     Stage payloads hold while stalled. out_valid and its payload never change until accepted.
//   S1: registers op, sat_en, a, b. S2 computes and registers result and flags.
//   Arithmetic: ADD, SUB, NEG and ABS are computed in WIDTH+1 bits.
//     ovf = 1 when the value lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//     Wrap: result = low WIDTH bits, sign-extended to 2*WIDTH.
//     Saturate: result = MAX (2^(WIDTH-1)-1) for positive overflow and MIN for negative
//     overflow, both sign-extended. ovf is 1 in either mode.
//   MUL: full 2*WIDTH signed product. ovf is always 0, because MIN*MIN fits. sat_en is ignored.
//   NEG(MIN) and ABS(MIN): ovf = 1. Result is MIN when wrapping and MAX when saturating.
//   CMP: result = 0, ovf = 0, cmp_gt and cmp_eq use signed comparison.
//   Reserved op: result = 0 and all flags are 0. The beat still flows through the pipeline.
//   ovf_count: increments on each output handshake with ovf = 1. It holds at 2^CNT_W-1.
//     clr_count has priority over increment, giving 0 on the next cycle even if an increment coincides.
//   Reset mid-operation: in-flight beats are discarded, with no partial output.
// TESTING (WIDTH=8, CNT_W=8)
//   1. ADD 0x7F+0x01: sat_en=0 gives result=-128, ovf=1; sat_en=1 gives result=127, ovf=1.
//      Both arrive 2 cycles after the handshake.
//   2. SUB 0x80-0x01 with sat_en=0 gives 127, ovf=1. SUB 0x7F-0xFF with sat_en=1 gives 127, ovf=1.
//      ADD 0x80+0xFF with sat_en=1 gives -128, ovf=1.
//   3. MUL 0x40*0x40 gives 4096, ovf=0. MUL 0x80*0x80 gives 16384. MUL 0x80*0x7F gives -16256.
//   4. CMP 0x7F,0x80 gives cmp_gt=1. CMP 0x00,0xFF gives cmp_gt=1. CMP 0xFF,0xFF gives cmp_eq=1, cmp_gt=0.
//      NEG/ABS of 0x80 with sat_en=1 gives 127, ovf=1.
//   5. Stream 10 back-to-back beats while out_ready toggles randomly.
//      Results must match the model in order, with no drops or duplicates.
//      out_valid and result must be stable under stall; in_ready must be 0 only when both stages are full.
//   6. Drive 300 overflowing beats: ovf_count stops at 255. Pulse clr_count while an ovf handshake
//      occurs in the same cycle: count becomes 0. Assert rst_n low mid-stream: out_valid=0 at once.

Source files
------------

// File: rtl/signed_alu_pipe.sv
// Two-stage pipelined signed ALU (add/sub/mul/neg/abs/cmp) with wrap or saturate per beat,
// overflow flag and a saturating overflow event counter, on valid/ready streams.
module signed_alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic               sat_en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf,
  output logic               cmp_gt,
  output logic               cmp_eq,
  input  logic               clr_count,
  output logic [CNT_W-1:0]   ovf_count
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpNeg = 3'd3;
  localparam logic [2:0] OpAbs = 3'd4;
  localparam logic [2:0] OpCmp = 3'd5;

  localparam logic [2*WIDTH-1:0] MaxExt = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MinExt = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
  localparam logic [CNT_W-1:0]   CntMax = '1;

  // Stage 1: registered operands
  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic             s1_sat_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Stage 2: registered result and flags
  logic               s2_valid_q;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic s1_adv, s2_adv;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_sat_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q  <= op;
        s1_sat_q <= sat_en;
        s1_a_q   <= a;
        s1_b_q   <= b;
      end
    end
  end

  logic signed [WIDTH:0]     a_x, b_x, ext_v;
  logic signed [2*WIDTH-1:0] a_w, b_w, prod;
  logic                      use_ext, ext_ovf;

  always_comb begin
    a_x      = {s1_a_q[WIDTH-1], s1_a_q};
    b_x      = {s1_b_q[WIDTH-1], s1_b_q};
    a_w      = {{WIDTH{s1_a_q[WIDTH-1]}}, s1_a_q};
    b_w      = {{WIDTH{s1_b_q[WIDTH-1]}}, s1_b_q};
    prod     = a_w * b_w;
    ext_v    = '0;
    use_ext  = 1'b0;
    result_d = '0;
    ovf_d    = 1'b0;
    gt_d     = 1'b0;
    eq_d     = 1'b0;
    case (s1_op_q)
      OpAdd: begin ext_v = a_x + b_x; use_ext = 1'b1; end
      OpSub: begin ext_v = a_x - b_x; use_ext = 1'b1; end
      OpNeg: begin ext_v = -a_x;      use_ext = 1'b1; end
      OpAbs: begin ext_v = a_x[WIDTH] ? -a_x : a_x; use_ext = 1'b1; end
      OpMul: result_d = prod;
      OpCmp: begin
        gt_d = $signed(s1_a_q) > $signed(s1_b_q);
        eq_d = s1_a_q == s1_b_q;
      end
      default: ;
    endcase
    // A WIDTH+1 value fits in WIDTH bits iff its top two bits agree
    ext_ovf = ext_v[WIDTH] ^ ext_v[WIDTH-1];
    if (use_ext) begin
      ovf_d = ext_ovf;
      if (ext_ovf && s1_sat_q) begin
        result_d = ext_v[WIDTH] ? MinExt : MaxExt;
      end else begin
        result_d = {{WIDTH{ext_v[WIDTH-1]}}, ext_v[WIDTH-1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        gt_q     <= gt_d;
        eq_q     <= eq_d;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (s2_valid_q && out_ready && ovf_q && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign cmp_gt    = gt_q;
  assign cmp_eq    = eq_q;
  assign ovf_count = count_q;

endmodule
